// File: rtl/perip_io_timer_if.sv
// perip_io_timer_if
// miniRV peripheral bus between the CPU (master) and an I/O responder (slave).
//   perip_addr  [31:0]  byte address, master -> slave
//   perip_wen           write strobe, master -> slave
//   perip_mask  [1:0]   access size 00 byte, 01 half, 10/11 word, master -> slave
//   perip_wdata [31:0]  right-aligned store data, master -> slave
//   perip_rdata [31:0]  combinational read data, slave -> master
//   perip_hit           address falls in the slave's window, slave -> master
interface perip_io_timer_if;
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;
    logic        perip_hit;

    modport master (
        output perip_addr, perip_wen, perip_mask, perip_wdata,
        input  perip_rdata, perip_hit
    );

    modport slave (
        input  perip_addr, perip_wen, perip_mask, perip_wdata,
        output perip_rdata, perip_hit
    );
endinterface

// File: rtl/perip_io_timer.sv
// perip_io_timer
// Memory-mapped I/O responder on the miniRV perip bus: LED register,
// synchronized switch inputs and a prescaled countdown timer with a sticky
// expiry flag.
//
// Ports:
//   i_cpu_clk      single clock
//   i_cpu_rst      synchronous active-high reset
//   bus            perip bus, slave side (rdata/hit are combinational)
//   i_sw  [SW_W]   asynchronous board switches
//   o_led [LED_W]  LED register value
//   o_timer_irq    registered expired & irq_en (only with PERIP_IO_TIMER_IRQ_EN)
//
// Build option: PERIP_IO_TIMER_IRQ_EN adds o_timer_irq and CTRL bit2 irq_en.
//
// Register map (offset = addr[11:0], word aligned):
//   0x000 LED  R/W   0x004 SW  RO   0x010 CTRL {irq_en,reload,en}
//   0x014 PERIOD R/W 0x018 COUNT RO 0x01C STATUS bit0 expired, W1C
//
// Timer states:
//   state   | meaning
//   ST_IDLE | en=0, prescaler held at 0, COUNT held
//   ST_RUN  | en=1, prescaler running, COUNT decrements on each tick
module perip_io_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
    parameter int          PRESCALE  = 1000,
    parameter int          LED_W     = 24,
    parameter int          SW_W      = 24
) (
    input  logic                  i_cpu_clk,
    input  logic                  i_cpu_rst,
    perip_io_timer_if.slave       bus,
    input  logic [SW_W-1:0]       i_sw,
`ifdef PERIP_IO_TIMER_IRQ_EN
    output logic                  o_timer_irq,
`endif
    output logic [LED_W-1:0]      o_led
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            r_state;
    logic [LED_W-1:0]  r_led;
    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic              r_reload;
    logic              r_irq_en;
    logic [31:0]       r_period;
    logic [31:0]       r_count;
    logic              r_expired;
    logic [PW-1:0]     r_pre_cnt;
    logic              r_irq;

    logic              w_hit;
    logic [9:0]        w_word;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_bmask;
    logic              w_wr;
    logic              w_wr_led;
    logic              w_wr_ctrl;
    logic              w_wr_period;
    logic              w_w1c;
    logic              w_tick;
    logic              w_expire;
    logic [PW-1:0]     w_pre_next;
    logic [31:0]       w_led_merged;
    logic [31:0]       w_period_merged;
    logic [31:0]       w_ctrl_rd;
    logic [31:0]       w_rdata;

    assign w_hit  = (bus.perip_addr[31:12] == BASE_ADDR[31:12]);
    assign w_word = bus.perip_addr[11:2];

    // Byte-lane enables; a misaligned half-word enables nothing and is dropped.
    always_comb begin
        w_be = 4'b0000;
        case (bus.perip_mask)
            2'b00:   w_be = 4'b0001 << bus.perip_addr[1:0];
            2'b01:   w_be = bus.perip_addr[0] ? 4'b0000
                          : (bus.perip_addr[1] ? 4'b1100 : 4'b0011);
            default: w_be = 4'b1111;
        endcase
    end

    // Replicating the right-aligned data puts it on every lane it could target.
    always_comb begin
        w_wd = bus.perip_wdata;
        case (bus.perip_mask)
            2'b00:   w_wd = {4{bus.perip_wdata[7:0]}};
            2'b01:   w_wd = {2{bus.perip_wdata[15:0]}};
            default: w_wd = bus.perip_wdata;
        endcase
    end

    assign w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    assign w_wr        = bus.perip_wen && w_hit && (w_be != 4'b0000);
    assign w_wr_led    = w_wr && (w_word == 10'h000);
    assign w_wr_ctrl   = w_wr && (w_word == 10'h004);
    assign w_wr_period = w_wr && (w_word == 10'h005);
    assign w_w1c       = w_wr && (w_word == 10'h007) && w_be[0] && w_wd[0];

    assign w_led_merged    = (32'(r_led) & ~w_bmask) | (w_wd & w_bmask);
    assign w_period_merged = (r_period   & ~w_bmask) | (w_wd & w_bmask);

    assign w_tick     = (r_state == ST_RUN) && (r_pre_cnt == PW'(PRESCALE - 1));
    assign w_pre_next = w_tick ? '0 : r_pre_cnt + PW'(1);
    // A CTRL write in the same cycle discards the tick, so no expiry either.
    assign w_expire   = w_tick && !w_wr_ctrl && (r_count == 32'd0);

    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rst) begin
            r_state   <= ST_IDLE;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_reload  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_period  <= 32'd0;
            r_count   <= 32'd0;
            r_expired <= 1'b0;
            r_pre_cnt <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_sw_meta <= i_sw;
            r_sw_sync <= r_sw_meta;
            r_irq     <= r_expired & r_irq_en;

            if (w_wr_led)
                r_led <= w_led_merged[LED_W-1:0];
            if (w_wr_period)
                r_period <= w_period_merged;
            if (w_wr_ctrl && w_be[0]) begin
                r_reload <= w_wd[1];
`ifdef PERIP_IO_TIMER_IRQ_EN
                r_irq_en <= w_wd[2];
`endif
            end

            // Set beats a simultaneous W1C.
            if (w_expire)
                r_expired <= 1'b1;
            else if (w_w1c)
                r_expired <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_pre_cnt <= '0;
                    if (w_wr_ctrl && w_be[0] && w_wd[0]) begin
                        r_state <= ST_RUN;
                        r_count <= r_period;
                    end
                end
                ST_RUN: begin
                    if (w_wr_ctrl) begin
                        if (w_be[0] && !w_wd[0]) begin
                            r_state   <= ST_IDLE;
                            r_pre_cnt <= '0;
                        end else begin
                            r_pre_cnt <= w_pre_next;
                        end
                    end else begin
                        r_pre_cnt <= w_pre_next;
                        if (w_tick) begin
                            if (r_count != 32'd0)
                                r_count <= r_count - 32'd1;
                            else if (r_reload)
                                r_count <= r_period;
                            else
                                r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_ctrl_rd = {29'd0, r_irq_en, r_reload, (r_state == ST_RUN)};

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_word)
                10'h000: w_rdata = 32'(r_led);
                10'h001: w_rdata = 32'(r_sw_sync);
                10'h004: w_rdata = w_ctrl_rd;
                10'h005: w_rdata = r_period;
                10'h006: w_rdata = r_count;
                10'h007: w_rdata = {31'd0, r_expired};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.perip_rdata = w_rdata;
    assign bus.perip_hit   = w_hit;
    assign o_led           = r_led;
`ifdef PERIP_IO_TIMER_IRQ_EN
    assign o_timer_irq     = r_irq;
`endif

    // Bits of the merged LED word beyond LED_W have no destination.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_led_merged, r_irq};

endmodule
